// File: rtl/shared_buff_free_slot_alloc_pkg.sv
// Shared-buffer common types and helpers: slot encoding, NULL pointer, one-hot and popcount checks.
package shared_buff_pkg;

  localparam int unsigned SB_D      = 4;
  localparam int unsigned MAX_SLOTS = 64;

  typedef logic [SB_D-1:0]      slot_t;
  typedef logic [MAX_SLOTS-1:0] wide_slot_t;

  localparam slot_t NULL_PTR = '0;

  // Helpers take a zero-extended slot so any buffer depth up to MAX_SLOTS can share them.
  function automatic logic is_onehot(input wide_slot_t v);
    return (v != '0) && ((v & (v - MAX_SLOTS'(1))) == '0);
  endfunction

  function automatic int unsigned popcount(input wide_slot_t v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(MAX_SLOTS); i++) begin
      n = n + {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/shared_buff_free_slot_alloc_onehot_rr_pick.sv
// Round-robin one-hot picker: first request strictly above 'last', wrapping; grant is 0 when no request.
module onehot_rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] last,
  output logic [N-1:0] grant
);

  localparam int unsigned W2 = 2 * N;

  logic [N-1:0]  above;
  logic [W2-1:0] dbl;
  logic [W2-1:0] pick;

  // Lower half holds requests above 'last'; upper half is the wrapped copy searched next.
  always_comb begin
    above = ~((last << 1) - N'(1));
    dbl   = {req, req & above};
    pick  = dbl & (~dbl + W2'(1));
    grant = pick[N-1:0] | pick[W2-1:N];
  end

endmodule

// File: rtl/shared_buff_free_slot_alloc.sv
// Free-slot manager for the shared buffer: offers a one-hot slot per push, reclaims the slot of each pop.
module shared_buff_free_slot_alloc
  import shared_buff_pkg::*;
#(
  parameter  int unsigned D  = SB_D,
  localparam int unsigned CW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          alloc_i,
  output logic          alloc_ready_o,
  output logic [D-1:0]  alloc_slot_o,
  input  logic          free_i,
  input  logic [D-1:0]  free_slot_i,
  output logic [CW-1:0] free_cnt_o,
  output logic          err_underflow_o,
  output logic          err_bad_free_o
);

  logic [D-1:0]  free_map;
  logic [D-1:0]  rr_ptr;
  logic [D-1:0]  offer;
  logic [D-1:0]  alloc_clr;
  logic [D-1:0]  free_set;
  logic [CW-1:0] free_cnt;
  logic          err_underflow;
  logic          err_bad_free;
  logic          ready;
  logic          accept;
  logic          free_ok;

  onehot_rr_pick #(.N(D)) u_pick (
    .req   (free_map),
    .last  (rr_ptr),
    .grant (offer)
  );

  // A free is valid only for a one-hot slot currently marked allocated; the offered slot is still free here.
  always_comb begin
    ready     = |free_map;
    accept    = alloc_i & ready;
    free_ok   = free_i && is_onehot(MAX_SLOTS'(free_slot_i)) && ((free_slot_i & free_map) == '0);
    alloc_clr = accept  ? offer       : '0;
    free_set  = free_ok ? free_slot_i : '0;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      free_map      <= '1;
      rr_ptr        <= D'(1) << (D - 1);
      free_cnt      <= CW'(D);
      err_underflow <= 1'b0;
      err_bad_free  <= 1'b0;
    end else begin
      free_map <= (free_map & ~alloc_clr) | free_set;
      if (accept) rr_ptr <= offer;
      if (accept && !free_ok)      free_cnt <= free_cnt - CW'(1);
      else if (free_ok && !accept) free_cnt <= free_cnt + CW'(1);
      if (alloc_i && !ready)  err_underflow <= 1'b1;
      if (free_i && !free_ok) err_bad_free  <= 1'b1;
    end
  end

  assign alloc_ready_o   = ready;
  assign alloc_slot_o    = offer;
  assign free_cnt_o      = free_cnt;
  assign err_underflow_o = err_underflow;
  assign err_bad_free_o  = err_bad_free;

  a_cnt_matches_map: assert property (@(posedge clk) disable iff (!arst_n)
    32'(free_cnt) == popcount(MAX_SLOTS'(free_map)));

endmodule
